// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, master state type and burst length helper
package ahb_pkg;
  typedef enum logic [1:0] {HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11} htrans_t;
  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000, HBURST_INCR = 3'b001, HBURST_WRAP4 = 3'b010, HBURST_INCR4 = 3'b011,
    HBURST_WRAP8 = 3'b100, HBURST_INCR8 = 3'b101, HBURST_WRAP16 = 3'b110, HBURST_INCR16 = 3'b111
  } hburst_t;
  typedef enum logic [1:0] {HRESP_OKAY = 2'b00, HRESP_ERROR = 2'b01} hresp_t;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    return (burst == HBURST_INCR16 || burst == HBURST_WRAP16) ? 5'd16 :
           (burst == HBURST_INCR8 || burst == HBURST_WRAP8) ? 5'd8 :
           (burst == HBURST_INCR4 || burst == HBURST_WRAP4) ? 5'd4 : 5'd1;
  endfunction
endpackage

// File: rtl/ahb_addr_gen.sv
// ahb_addr_gen: next beat address for incrementing and wrapping bursts
module ahb_addr_gen import ahb_pkg::*; #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [2:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  logic [ADDR_WIDTH-1:0] sum, mask;
  logic wrap;
  always_comb begin
    sum = addr + (ADDR_WIDTH'(1) << size);
    mask = (ADDR_WIDTH'(burst_beats(burst)) << size) - ADDR_WIDTH'(1);
    wrap = burst inside {HBURST_WRAP4, HBURST_WRAP8, HBURST_WRAP16};
    next_addr = wrap ? (addr & ~mask) | (sum & mask) : sum;
  end
endmodule

// File: rtl/ahb_master.sv
// ahb_master: AHB-Lite initiator turning single commands into SINGLE/INCRn/WRAPn transfers
module ahb_master import ahb_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [2:0]            cmd_burst,
  input  logic [DATA_WIDTH-1:0] wd_data,
  output logic                  wd_pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  done_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP
);
  state_t state, state_nx;
  logic [4:0] left, left_nx;
  logic [ADDR_WIDTH-1:0] next_addr, addr_nx;
  logic [DATA_WIDTH-1:0] rd_data_nx;
  logic [1:0] trans_nx;
  logic [2:0] size_nx, burst_nx;
  logic write_nx, rd_valid_nx, done_nx, done_err_nx, dp, dp_wr, err_first;
  ahb_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_gen (
    .addr(HADDR), .size(HSIZE), .burst(HBURST), .next_addr(next_addr)
  );
  assign dp = state == S_LAST || state == S_ERR || (state == S_ADDR && HTRANS == HTRANS_SEQ);
  assign dp_wr = dp && HWRITE;
  assign err_first = dp && !HREADY && HRESP == HRESP_ERROR;
  assign cmd_ready = state == S_IDLE;
  assign HWDATA = dp_wr ? wd_data : '0;
  assign wd_pop = dp_wr && HREADY;
  assign HPROT = HPROT_DEFAULT;
  always_comb begin
    state_nx = state;
    addr_nx = HADDR;
    trans_nx = HTRANS;
    write_nx = HWRITE;
    size_nx = HSIZE;
    burst_nx = HBURST;
    left_nx = left;
    rd_data_nx = rd_data;
    rd_valid_nx = 1'b0;
    done_nx = 1'b0;
    done_err_nx = 1'b0;
    if (state == S_IDLE) begin
      if (cmd_valid) begin
        state_nx = S_ADDR;
        addr_nx = cmd_addr;
        trans_nx = HTRANS_NONSEQ;
        write_nx = cmd_write;
        size_nx = cmd_size;
        burst_nx = cmd_burst == HBURST_INCR ? HBURST_SINGLE : cmd_burst;
        left_nx = burst_beats(cmd_burst) - 5'd1;
      end
    end else if (state == S_ERR) begin
      if (HREADY) begin
        state_nx = S_IDLE;
        done_nx = 1'b1;
        done_err_nx = 1'b1;
      end
    end else if (err_first) begin
      state_nx = S_ERR;
      trans_nx = HTRANS_IDLE;
    end else if (HREADY) begin
      if (dp && !HWRITE) begin
        rd_valid_nx = 1'b1;
        rd_data_nx = HRDATA;
      end
      if (state == S_LAST) begin
        state_nx = S_IDLE;
        done_nx = 1'b1;
      end else if (left == 5'd0) begin
        state_nx = S_LAST;
        trans_nx = HTRANS_IDLE;
      end else begin
        addr_nx = next_addr;
        trans_nx = HTRANS_SEQ;
        left_nx = left - 5'd1;
      end
    end
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= S_IDLE;
      HADDR <= '0;
      HTRANS <= HTRANS_IDLE;
      HWRITE <= 1'b0;
      HSIZE <= '0;
      HBURST <= '0;
      left <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      done <= 1'b0;
      done_err <= 1'b0;
    end else begin
      state <= state_nx;
      HADDR <= addr_nx;
      HTRANS <= trans_nx;
      HWRITE <= write_nx;
      HSIZE <= size_nx;
      HBURST <= burst_nx;
      left <= left_nx;
      rd_data <= rd_data_nx;
      rd_valid <= rd_valid_nx;
      done <= done_nx;
      done_err <= done_err_nx;
    end
  end
endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: table-driven and randomized checks of ahb_master against a burst-level model
module tb_ahb_master;
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    int          waits;
    logic        err_en;
    logic [31:0] err_addr;
    int          exp_naddr;
    logic [31:0] exp_last;
    logic        exp_err;
  } vec_t;
  logic HCLK = 1'b0, HRESET = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [2:0] cmd_size = '0, cmd_burst = '0;
  logic [31:0] wd_data, rd_data, HADDR, HWDATA, HRDATA;
  logic wd_pop, rd_valid, done, done_err, HWRITE, HREADY;
  logic [1:0] HTRANS, HRESP;
  logic [2:0] HSIZE, HBURST;
  logic [3:0] HPROT;
  int checks = 0, failures = 0;
  int beats_of[8] = '{1, 1, 4, 4, 8, 8, 16, 16};
  int waits = 0;
  logic err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic dp_act = 1'b0, dp_wr = 1'b0, err_ph = 1'b0, is_err;
  logic [31:0] dp_addr = '0;
  int wcnt = 0;
  logic [31:0] wmem[64];
  int pops = 0;
  logic [31:0] aq[$], wq[$], rq[$];
  int cyc = 0, ns_cyc = -1, done_cyc = 0, done_cnt = 0;
  logic last_err = 1'b0, p_hold = 1'b0, p_efirst = 1'b0;
  logic [31:0] p_addr = '0;
  logic [1:0] p_trans = '0;
  logic [2:0] exp_size = '0, exp_burst = '0;
  logic exp_write = 1'b0;
  vec_t tbl[10];
  always #5 HCLK = ~HCLK;
  ahb_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_data(wd_data), .wd_pop(wd_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .done_err(done_err), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  assign is_err = dp_act && err_en && dp_addr == err_addr;
  assign HREADY = !dp_act || (is_err ? err_ph : wcnt >= waits);
  assign HRESP = is_err ? 2'b01 : 2'b00;
  assign HRDATA = (dp_act && !dp_wr) ? dp_addr >> 2 : '0;
  assign wd_data = wmem[pops[5:0]];
  always @(posedge HCLK) begin
    if (wd_pop) pops <= pops + 1;
    if (HRESET) begin
      dp_act <= 1'b0;
      wcnt <= 0;
      err_ph <= 1'b0;
    end else if (HREADY) begin
      dp_act <= HTRANS[1];
      dp_addr <= HADDR;
      dp_wr <= HWRITE;
      wcnt <= 0;
      err_ph <= 1'b0;
    end else begin
      wcnt <= wcnt + 1;
      err_ph <= is_err;
    end
  end
  always @(negedge HCLK) begin
    cyc++;
    if (!HRESET) begin
      if (p_hold && !p_efirst) begin
        chk("haddr_hold", HADDR, p_addr);
        chk("htrans_hold", 32'(HTRANS), 32'(p_trans));
      end
      if (p_efirst) chk("idle_after_err", 32'(HTRANS), 32'(0));
      if (HTRANS[1] && HREADY) begin
        aq.push_back(HADDR);
        chk("hsize", 32'(HSIZE), 32'(exp_size));
        chk("hburst", 32'(HBURST), 32'(exp_burst));
        chk("hwrite", 32'(HWRITE), 32'(exp_write));
      end
      if (HTRANS == 2'b10 && ns_cyc < 0) ns_cyc = cyc;
      if (wd_pop) wq.push_back(HWDATA);
      if (rd_valid) rq.push_back(rd_data);
      if (done) begin
        done_cnt++;
        last_err = done_err;
        done_cyc = cyc;
      end
    end
    p_hold = !HRESET && HTRANS[1] && !HREADY;
    p_efirst = !HRESET && dp_act && !HREADY && HRESP == 2'b01;
    p_addr = HADDR;
    p_trans = HTRANS;
  end
  function automatic logic is_wrap(input logic [2:0] b);
    return b inside {3'd2, 3'd4, 3'd6};
  endfunction
  function automatic logic [31:0] model_addr(input vec_t v, input int k);
    int bytes = 1 << v.size;
    int blk = beats_of[v.burst] * bytes;
    logic [31:0] base = v.addr / blk * blk;
    return is_wrap(v.burst) ? base + (v.addr - base + k * bytes) % blk : v.addr + k * bytes;
  endfunction
  task automatic issue(input vec_t v);
    waits = v.waits;
    err_en = v.err_en;
    err_addr = v.err_addr;
    exp_size = v.size;
    exp_write = v.write;
    exp_burst = v.burst == 3'b001 ? 3'b000 : v.burst;
    @(posedge HCLK);
    #1;
    cmd_valid = 1'b1;
    cmd_addr = v.addr;
    cmd_write = v.write;
    cmd_size = v.size;
    cmd_burst = v.burst;
    @(negedge HCLK);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'(1));
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    @(negedge HCLK);
    chk("cmd_ready_busy", 32'(cmd_ready), 32'(0));
  endtask
  task automatic run_cmd(input vec_t v);
    int nb, e, na, d0, p0;
    logic [31:0] ea[$];
    nb = beats_of[v.burst];
    e = nb;
    for (int k = 0; k < nb; k++) begin
      ea.push_back(model_addr(v, k));
      if (v.err_en && e == nb && ea[k] == v.err_addr) e = k;
    end
    na = e < nb ? e + 1 : nb;
    if (!is_wrap(v.burst) && !v.err_en)
      assert (v.addr[31:10] == ea[nb-1][31:10]) else $error("INCR burst crosses a 1KB boundary");
    aq.delete();
    wq.delete();
    rq.delete();
    ns_cyc = -1;
    d0 = done_cnt;
    p0 = pops;
    issue(v);
    for (int t = 0; t < 800 && done_cnt == d0; t++) @(negedge HCLK);
    repeat (3) @(negedge HCLK);
    chk("done_once", 32'(done_cnt - d0), 32'(1));
    chk("done_err", 32'(last_err), 32'(e < nb));
    chk("n_addr", 32'(aq.size()), 32'(na));
    for (int k = 0; k < na && k < aq.size(); k++) chk("haddr", aq[k], ea[k]);
    chk("n_pop", 32'(wq.size()), 32'(v.write ? na : 0));
    for (int k = 0; k < wq.size() && k < na; k++) chk("hwdata", wq[k], wmem[6'(p0 + k)]);
    chk("n_rd", 32'(rq.size()), 32'(v.write ? 0 : (e < nb ? e : nb)));
    for (int k = 0; k < rq.size() && k < nb; k++) chk("rd_data", rq[k], ea[k] >> 2);
    if (v.waits == 0 && e == nb) chk("done_latency", 32'(done_cyc - ns_cyc), 32'(nb + 1));
  endtask
  initial begin
    vec_t v;
    int nb, bytes, d0;
    for (int i = 0; i < 64; i++) wmem[i] = $urandom;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 32'(0));
    chk("rst_haddr", HADDR, 32'(0));
    chk("rst_hwrite", 32'(HWRITE), 32'(0));
    chk("rst_hsize", 32'(HSIZE), 32'(0));
    chk("rst_hburst", 32'(HBURST), 32'(0));
    chk("rst_hwdata", HWDATA, 32'(0));
    chk("rst_hprot", 32'(HPROT), 32'(3));
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst_wd_pop", 32'(wd_pop), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_rd_data", rd_data, 32'(0));
    chk("rst_done", 32'({done, done_err}), 32'(0));
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    tbl[0] = '{32'h10, 1'b1, 3'd2, 3'd0, 0, 1'b0, 32'h0, 1, 32'h10, 1'b0};
    tbl[1] = '{32'h100, 1'b0, 3'd2, 3'd3, 2, 1'b0, 32'h0, 4, 32'h10C, 1'b0};
    tbl[2] = '{32'h38, 1'b1, 3'd2, 3'd2, 0, 1'b0, 32'h0, 4, 32'h34, 1'b0};
    tbl[3] = '{32'hFF8, 1'b0, 3'd2, 3'd5, 0, 1'b1, 32'h1000, 3, 32'h1000, 1'b1};
    tbl[4] = '{32'h5, 1'b1, 3'd0, 3'd0, 0, 1'b0, 32'h0, 1, 32'h5, 1'b0};
    tbl[5] = '{32'h1E, 1'b0, 3'd1, 3'd4, 1, 1'b0, 32'h0, 8, 32'h1C, 1'b0};
    tbl[6] = '{32'h80, 1'b1, 3'd2, 3'd1, 0, 1'b0, 32'h0, 1, 32'h80, 1'b0};
    tbl[7] = '{32'h47, 1'b1, 3'd0, 3'd6, 0, 1'b0, 32'h0, 16, 32'h46, 1'b0};
    tbl[8] = '{32'h20, 1'b1, 3'd2, 3'd2, 0, 1'b1, 32'h20, 1, 32'h20, 1'b1};
    tbl[9] = '{32'h300, 1'b0, 3'd2, 3'd3, 1, 1'b1, 32'h30C, 4, 32'h30C, 1'b1};
    wmem[pops[5:0]] = 32'hDEADBEEF;
    foreach (tbl[i]) begin
      run_cmd(tbl[i]);
      chk("tbl_naddr", 32'(aq.size()), 32'(tbl[i].exp_naddr));
      chk("tbl_last", aq.size() > 0 ? aq[aq.size()-1] : 32'hFFFF_FFFF, tbl[i].exp_last);
      chk("tbl_err", 32'(last_err), 32'(tbl[i].exp_err));
    end
    v = '{32'h200, 1'b1, 3'd2, 3'd7, 1, 1'b0, 32'h0, 0, 32'h0, 1'b0};
    aq.delete();
    d0 = done_cnt;
    issue(v);
    for (int t = 0; t < 100 && aq.size() < 2; t++) @(negedge HCLK);
    @(posedge HCLK);
    #1 HRESET = 1'b1;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("rstb_htrans", 32'(HTRANS), 32'(0));
    chk("rstb_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rstb_haddr", HADDR, 32'(0));
    chk("rstb_done", 32'(done), 32'(0));
    repeat (20) @(negedge HCLK);
    chk("rstb_no_done", 32'(done_cnt - d0), 32'(0));
    run_cmd('{32'h44, 1'b0, 3'd2, 3'd0, 0, 1'b0, 32'h0, 1, 32'h44, 1'b0});
    for (int r = 0; r < 40; r++) begin
      v.size = 3'($urandom_range(0, 2));
      v.burst = 3'($urandom_range(0, 7));
      v.write = 1'($urandom);
      v.waits = $urandom_range(0, 2);
      nb = beats_of[v.burst];
      bytes = 1 << v.size;
      if (is_wrap(v.burst)) v.addr = ($urandom & 32'hFFFF) & ~32'(bytes - 1);
      else v.addr = (($urandom & 32'h3F) << 10) | 32'($urandom_range(0, 1024 / bytes - nb) * bytes);
      v.err_en = $urandom_range(0, 3) == 0;
      v.err_addr = model_addr(v, $urandom_range(0, nb - 1));
      run_cmd(v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
